// File: rtl/umul_bi_seq_if.sv
// Job and multiplier-side signals of the uMUL_bi sequencer.
// slave is the sequencer's view; master is the view of whoever drives it.
interface umul_bi_seq_if #(
  parameter int BITWIDTH = 8
);
  logic                  iValid;
  logic                  oReady;
  logic [BITWIDTH-1:0]   iA;
  logic [BITWIDTH-1:0]   iB;
  logic                  iAbort;
  logic                  oLoadB;
  logic                  oClr;
  logic [BITWIDTH-1:0]   oB;
  logic                  oABit;
  logic                  iMult;
  logic                  oValid;
  logic                  iReady;
  logic [BITWIDTH:0]     oCount;
  logic [BITWIDTH+1:0]   oResultBi;
  logic                  oBusy;

  modport slave (
    input  iValid, iA, iB, iAbort, iMult, iReady,
    output oReady, oLoadB, oClr, oB, oABit, oValid, oCount, oResultBi, oBusy
  );

  modport master (
    output iValid, iA, iB, iAbort, iMult, iReady,
    input  oReady, oLoadB, oClr, oB, oABit, oValid, oCount, oResultBi, oBusy
  );
endinterface

// File: rtl/umul_bi_seq.sv
// Sequencer for the bipolar stochastic multiplier: loads B, streams A as a
// bit-reversed-counter bitstream for 2^BITWIDTH cycles and counts output ones.
module umul_bi_seq #(
  parameter int BITWIDTH = 8
) (
  input  logic iClk,
  input  logic iRst,
  umul_bi_seq_if.slave bus
);

  localparam int                  LEN    = 1 << BITWIDTH;
  localparam logic [BITWIDTH-1:0] K_LAST = '1;
  localparam logic [BITWIDTH+1:0] LEN_BI = (BITWIDTH+2)'(LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  rst_q;
  logic [BITWIDTH-1:0]   a_q, a_d;
  logic [BITWIDTH-1:0]   b_q, b_d;
  logic [BITWIDTH-1:0]   k_q, k_d;
  logic [BITWIDTH:0]     acc_q, acc_d;
  logic [BITWIDTH:0]     cnt_q, cnt_d;
  logic [BITWIDTH+1:0]   res_q, res_d;

  logic                  ready;
  logic                  load_b;
  logic                  clr;
  logic                  a_bit;
  logic                  valid;
  logic                  busy;
  logic                  accept;
  logic [BITWIDTH-1:0]   k_rev;
  logic [BITWIDTH:0]     acc_sum;

  for (genvar gi = 0; gi < BITWIDTH; gi++) begin : g_rev
    assign k_rev[gi] = k_q[BITWIDTH-1-gi];
  end

  assign accept  = bus.iValid && ready;
  assign acc_sum = acc_q + (BITWIDTH+1)'(bus.iMult);

  // rst_q keeps oReady low for the cycle right after a reset edge.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      rst_q   <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: state_d = bus.iAbort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (bus.iAbort) begin
          state_d = S_IDLE;
        end else if (k_q == K_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: if (bus.iReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    load_b = 1'b0;
    clr    = 1'b0;
    a_bit  = 1'b0;
    valid  = 1'b0;
    busy   = 1'b0;
    case (state_q)
      S_IDLE: ready = !rst_q;
      S_LOAD: begin
        load_b = 1'b1;
        clr    = 1'b1;
        busy   = 1'b1;
      end
      S_RUN: begin
        a_bit = (a_q > k_rev);
        busy  = 1'b1;
      end
      S_DONE: valid = 1'b1;
      default: ;
    endcase
  end

  // An abort leaves k/acc stale; LOAD clears them before the next stream.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    k_d   = k_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d = bus.iA;
          b_d = bus.iB;
        end
      end
      S_LOAD: begin
        k_d   = '0;
        acc_d = '0;
      end
      S_RUN: begin
        if (!bus.iAbort) begin
          acc_d = acc_sum;
          k_d   = k_q + BITWIDTH'(1);
          if (k_q == K_LAST) begin
            cnt_d = acc_sum;
            // 2*count - LEN; modular arithmetic keeps the signed value exact.
            res_d = {acc_sum, 1'b0} - LEN_BI;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.oReady    = ready;
  assign bus.oLoadB    = load_b;
  assign bus.oClr      = clr;
  assign bus.oB        = b_q;
  assign bus.oABit     = a_bit;
  assign bus.oValid    = valid;
  assign bus.oCount    = cnt_q;
  assign bus.oResultBi = res_q;
  assign bus.oBusy     = busy;

endmodule

// File: tb/tb_umul_bi_seq.sv
// Directed bench for umul_bi_seq: reset, full jobs with several iMult
// patterns, result backpressure and aborts.
module tb_umul_bi_seq;
  localparam int BW  = 8;
  localparam int LEN = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mult_mode = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  umul_bi_seq_if #(.BITWIDTH(BW)) bus();

  umul_bi_seq #(.BITWIDTH(BW)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: constant 0, constant 1, or echo of the A bitstream.
  assign bus.iMult = (mult_mode == 2) ? bus.oABit : (mult_mode == 1);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic do_job(input logic [7:0] a, input logic [7:0] b, input int mode,
                        input int abort_k, input int hold, input logic [8:0] exp_cnt,
                        input logic [9:0] exp_res, input logic [3:0] exp_first4);
    logic [8:0] prev_cnt;
    logic [9:0] prev_res;
    logic [3:0] first4;
    int viol;
    int abit_err;
    int waited;
    prev_cnt  = bus.oCount;
    prev_res  = bus.oResultBi;
    mult_mode = mode;
    bus.iA     = a;
    bus.iB     = b;
    bus.iValid = 1'b1;
    waited = 0;
    while (bus.oReady !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check_eq("ready_before_job", 32'(bus.oReady), 32'd1);
    if (bus.oReady !== 1'b1) begin
      bus.iValid = 1'b0;
      return;
    end
    tick();
    bus.iValid = 1'b0;
    // cycle 1: LOAD
    check_eq("load_loadb", 32'(bus.oLoadB), 32'd1);
    check_eq("load_clr", 32'(bus.oClr), 32'd1);
    check_eq("load_ob", 32'(bus.oB), 32'(b));
    check_eq("load_busy", 32'(bus.oBusy), 32'd1);
    check_eq("load_ready", 32'(bus.oReady), 32'd0);
    tick();
    viol = 0;
    abit_err = 0;
    first4 = '0;
    for (int k = 0; k < LEN; k++) begin
      if (bus.oLoadB || bus.oClr || bus.oValid || bus.oReady || !bus.oBusy) viol++;
      if (bus.oABit !== (a > bitrev8(8'(k)))) abit_err++;
      if (k < 4) first4 = {first4[2:0], bus.oABit};
      if (k == 3) check_eq("first4_abits", 32'(first4), 32'(exp_first4));
      if (k == abort_k) begin
        bus.iAbort = 1'b1;
        tick();
        bus.iAbort = 1'b0;
        check_eq("abort_run_ctrl", 32'(viol), 32'd0);
        check_eq("abort_abit", 32'(abit_err), 32'd0);
        check_eq("abort_valid", 32'(bus.oValid), 32'd0);
        check_eq("abort_busy", 32'(bus.oBusy), 32'd0);
        check_eq("abort_ready", 32'(bus.oReady), 32'd1);
        check_eq("abort_count_kept", 32'(bus.oCount), 32'(prev_cnt));
        check_eq("abort_result_kept", 32'(bus.oResultBi), 32'(prev_res));
        viol = 0;
        for (int i = 0; i < 5; i++) begin
          tick();
          if (bus.oValid || bus.oBusy) viol++;
        end
        check_eq("abort_quiet", 32'(viol), 32'd0);
        $display("job A=%02h B=%02h mode=%0d aborted at k=%0d count=%0d", a, b, mode, k, bus.oCount);
        return;
      end
      tick();
    end
    // cycle LEN+2: DONE
    check_eq("run_ctrl", 32'(viol), 32'd0);
    check_eq("run_abit", 32'(abit_err), 32'd0);
    check_eq("done_valid", 32'(bus.oValid), 32'd1);
    check_eq("done_count", 32'(bus.oCount), 32'(exp_cnt));
    check_eq("done_result_bi", 32'(bus.oResultBi), 32'(exp_res));
    check_eq("done_busy", 32'(bus.oBusy), 32'd0);
    check_eq("done_ready", 32'(bus.oReady), 32'd0);
    check_eq("done_abit", 32'(bus.oABit), 32'd0);
    viol = 0;
    for (int h = 0; h < hold; h++) begin
      bus.iValid = h[0];
      tick();
      if (bus.oValid !== 1'b1 || bus.oCount !== exp_cnt ||
          bus.oResultBi !== exp_res || bus.oReady !== 1'b0) viol++;
    end
    bus.iValid = 1'b0;
    check_eq("hold_stable", 32'(viol), 32'd0);
    bus.iReady = 1'b1;
    tick();
    bus.iReady = 1'b0;
    check_eq("after_valid", 32'(bus.oValid), 32'd0);
    check_eq("after_ready", 32'(bus.oReady), 32'd1);
    check_eq("after_ob_kept", 32'(bus.oB), 32'(b));
    $display("job A=%02h B=%02h mode=%0d count=%0d result_bi=%0d", a, b, mode,
             bus.oCount, $signed(bus.oResultBi));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iValid = 1'b1;
    bus.iA     = 8'h11;
    bus.iB     = 8'h22;
    bus.iAbort = 1'b0;
    bus.iReady = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_ready", 32'(bus.oReady), 32'd0);
      check_eq("rst_valid", 32'(bus.oValid), 32'd0);
      check_eq("rst_count", 32'(bus.oCount), 32'd0);
      check_eq("rst_busy", 32'(bus.oBusy), 32'd0);
    end
    rst = 1'b0;
    tick();
    check_eq("rst_release_ready", 32'(bus.oReady), 32'd1);
    check_eq("rst_release_busy", 32'(bus.oBusy), 32'd0);
    bus.iValid = 1'b0;
    tick();
    check_eq("rst_no_job", 32'(bus.oBusy), 32'd0);
    $display("reset done ready=%0d", bus.oReady);

    do_job(8'h80, 8'h40, 1, -1, 0, 9'd256, 10'h100, 4'b1010);
    do_job(8'h80, 8'h33, 2, -1, 0, 9'd128, 10'h000, 4'b1010);
    do_job(8'h00, 8'h55, 0, -1, 0, 9'd0, 10'h300, 4'b0000);
    do_job(8'h40, 8'hA5, 2, -1, 10, 9'd64, 10'h380, 4'b1000);
    do_job(8'h80, 8'h11, 1, 100, 0, 9'd0, 10'h000, 4'b1010);
    do_job(8'h80, 8'h12, 1, 255, 0, 9'd0, 10'h000, 4'b1010);
    do_job(8'h80, 8'h13, 1, -1, 0, 9'd256, 10'h100, 4'b1010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/umul_bi_seq.md
Name: umul_bi_seq

Overview:
- Job sequencer for the bipolar stochastic multiplier `uMUL_bi`.
- Accepts one binary operand pair (A, B) through a valid/ready handshake.
- Loads B into the multiplier and clears its RNGs, then drives A as a bit-reversed-counter bitstream for 2^BITWIDTH cycles.
- Counts the multiplier's output ones and returns the unipolar count plus the signed bipolar result through a second valid/ready handshake.

Parameters:
- BITWIDTH, 8, operand width; stream length LEN = 2^BITWIDTH cycles.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iValid  in  1  job request.
- oReady  out  1  job accept; high only in IDLE.
- iA  in  BITWIDTH  operand A, unsigned code.
- iB  in  BITWIDTH  operand B, unsigned code.
- iAbort  in  1  cancels the job in flight.
- oLoadB  out  1  to multiplier loadB.
- oClr  out  1  to multiplier iClr.
- oB  out  BITWIDTH  to multiplier iB (registered B).
- oABit  out  1  to multiplier iA (A bitstream).
- iMult  in  1  from multiplier oMult.
- oValid  out  1  result valid.
- iReady  in  1  result accept.
- oCount  out  BITWIDTH+1  number of ones in the oMult stream, range 0..LEN.
- oResultBi  out  BITWIDTH+2  signed result, 2*oCount - LEN.
- oBusy  out  1  high in LOAD or RUN.

Behaviour:
- Reset (iRst high at an edge):
  - State goes to IDLE; cycle counter k and accumulator are cleared.
  - All outputs are 0, including oReady, during any cycle in which iRst was high at the preceding edge.
  - oReady rises the cycle after the first edge with iRst low.
  - Reset mid-job discards the job; no oValid is produced.
- States and outputs:
  - IDLE: oReady=1. On an edge with iValid & oReady, latch iA→aBuf and iB→bBuf, then go to LOAD.
  - LOAD (exactly 1 cycle): oLoadB=1, oClr=1. Clear k and the accumulator, then go to RUN.
  - RUN (exactly LEN cycles, k = 0..LEN-1):
    - oABit = (aBuf > bitrev(k)), where bitrev reverses the bit order of the BITWIDTH-bit k.
    - iMult is sampled at the same edge as k; the multiplier path is combinational.
    - Accumulator += iMult.
    - On the edge with k = LEN-1, load oCount with the final sum (including that edge's iMult) and go to DONE.
  - DONE: oValid=1. oCount and oResultBi are held stable until an edge with iReady=1, then go to IDLE.
- oB = bBuf in every state; bBuf persists after a job.
- oABit=0, oLoadB=0 and oClr=0 outside their active states.
- oResultBi = {0, oCount, 0} - LEN in two's complement. It is updated with oCount and spans -LEN..+LEN.
- Timing, with the accepting edge as edge 0:
  - LOAD occupies cycle 1.
  - RUN occupies cycles 2..LEN+1.
  - oValid is first high in cycle LEN+2 (258 for BITWIDTH=8).
- Throughput: at most one job per LEN+3 cycles. There is always at least one IDLE cycle between jobs; oReady is never high together with oValid.
- iValid outside IDLE is ignored; the job is not queued.
- iAbort:
  - In LOAD or RUN: go to IDLE at that edge. No oValid; oCount keeps its previous value.
  - Wins over the final RUN edge.
  - Ignored in IDLE and DONE.
- The accumulator needs BITWIDTH+1 bits and cannot overflow, since at most LEN ones are counted.

Test Plan:
1. Reset: hold iRst=1 for 3 cycles with iValid=1 → oReady=0, oValid=0, oCount=0, oBusy=0 throughout. Release → oReady=1 next cycle; no job is accepted during reset.
2. iMult tied to 1; A=0x80, B=0x40 → oLoadB=oClr=1 only in cycle 1 and oB=0x40. oBusy is high in cycles 1..257. oValid rises in cycle 258 with oCount=256 and oResultBi=+256.
3. iMult tied to oABit; A=0x80 → oABit in the first 4 RUN cycles is 1,0,1,0 (bitrev values 0x00, 0x80, 0x40, 0xC0). Final oCount=128, oResultBi=0.
4. iMult tied to 0; A=0x00 → oABit is 0 for all 256 RUN cycles; oCount=0, oResultBi=-256.
5. Backpressure: hold iReady=0 for 10 cycles in DONE while pulsing iValid → oValid, oCount and oResultBi stay stable and oReady=0. Then iReady=1 → IDLE with oReady=1 next cycle.
6. Abort:
   - iAbort at RUN k=100 → IDLE next cycle, no oValid, oCount unchanged.
   - Repeat with iAbort on k=255 → no oValid.
   - A following job with iMult=1 completes with oCount=256.
